// File: rtl/mux4_arb_pkg.sv
// Shared types for the 4-input round-robin mux arbiter.
//   NUM_REQ : number of requesters / mux data inputs
//   idx_t   : 2-bit requester index, also the {s1,s0} select encoding
//   state_t : arbiter FSM states
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, bit i = requester i
//   ptr   : index searched first; the search continues ptr+1, ptr+2, ... mod 4
//   found : at least one request is active
//   idx   : first active requester in search order (equals ptr when none found)
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               ptr,
    output logic               found,
    output idx_t               idx
);

    idx_t cand;

    // NOTE: every variable assigned in this block gets a value before any
    // condition, so no path leaves it holding state and no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            // 2-bit addition wraps naturally, giving the mod-4 search order.
            cand = ptr + idx_t'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter owning the selects of a shared 4:1 mux.
// A winner keeps the mux for at most MAX_HOLD cycles (or until it drops its
// request), then a one-cycle all-zero gap separates it from the next owner.
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   req  : request lines, bit i asks for mux input d_i
//   gnt  : one-hot grant, or zero when nobody owns the mux
//   s0   : mux select bit 0 (owner index LSB)
//   s1   : mux select bit 1 (owner index MSB)
//   busy : high while gnt is nonzero
module mux4_rr_arb
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s0,
    output logic               s1,
    output logic               busy
);

    localparam int            CW   = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    state_t        state, state_nxt;
    idx_t          owner, owner_nxt;
    idx_t          ptr, ptr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          found;
    idx_t          pick;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE, GAP: begin
                if (found) begin
                    state_nxt = OWN;
                    owner_nxt = pick;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN: begin
                // Request drop and timeout share one release path, so a
                // coincidence still yields a single gap and one ptr step.
                if (!req[owner] || cnt == LAST) begin
                    state_nxt = GAP;
                    ptr_nxt   = owner + idx_t'(1);
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Owner is only reloaded on a grant, so the selects hold their last
    // value through GAP and IDLE.
    assign gnt  = (state == OWN) ? (NUM_REQ'(1) << owner) : '0;
    assign s0   = owner[0];
    assign s1   = owner[1];
    assign busy = (state == OWN);

endmodule
